stack_sequencer: RTL and testbench
==================================

// Module: stack_sequencer
// PURPOSE
//  Command-side controller for the 4-bit LIFO (stack_register). Accepts calculator commands over a
//  valid/ready handshake and drives the stack's mode/in_word inputs as multi-cycle push/pop sequences.
//  Reads back top_word/second_word, tracks depth, and flags overflow/underflow. Sits between the
//  chip input decode and the stack.
// PARAMETERS
//  STACK_SIZE  8  stack depth; must match the stack instance; depth counter is $clog2(STACK_SIZE+1) bits
// PORTS
//  clk          in   1  single clock; all state updates on posedge
//  reset        in   1  synchronous, active-high
//  cmd_valid    in   1  command present
//  cmd          in   3  opcode (see BEHAVIOUR)
//  cmd_data     in   4  immediate for PUSH
//  cmd_ready    out  1  high only in IDLE; transfer = cmd_valid & cmd_ready at posedge
//  stack_mode   out  3  registered; drives stack mode
//  stack_in     out  4  registered; drives stack in_word
//  top_word     in   4  stack top (from stack)
//  second_word  in   4  stack second entry
//  depth        out  4  live entry count, 0..STACK_SIZE
//  carry        out  1  ADD carry-out / SUB borrow of last arithmetic op
//  err_overflow out  1  sticky
//  err_underflow out 1  sticky
// BEHAVIOUR
//  Reset: state=IDLE, stack_mode=HOLD, stack_in=0, depth=0, carry=0, both errors=0. Stack contents are
//   not cleared; they are logically empty. Reset mid-sequence aborts it; no further push/pop is issued.
//  Opcodes: 000 NOP, 001 PUSH, 010 POP, 011 DUP, 100 ADD, 101 SUB, 110 SWAP, 111 CLRERR.
//  Timing: mode/in_word are registered; a value driven in cycle k shifts the stack at the end of cycle k.
//   Depth updates on the same edge. Outside sequences, stack_mode=HOLD.
//  Accept at edge N: operands a=top_word, b=second_word latched at N.
//  Sequences (cycles after N):
//   PUSH  N+1 PUSH d
//   POP   N+1 POP
//   DUP   N+1 PUSH a
//   ADD   N+1 POP; N+2 POP; N+3 PUSH (b+a)[3:0]; carry=(b+a)[4]
//   SUB   as ADD with (b-a) mod 16; carry=borrow (a>b)
//   SWAP  N+1 POP; N+2 POP; N+3 PUSH a; N+4 PUSH b  -> top=b, second=a
//   IDLE is re-entered the cycle after the last op.
//   carry is updated on the edge that applies the result PUSH.
//  FSM: IDLE -> S1 -> S2 -> S3 -> S4 -> IDLE. Short ops return to IDLE after S1. cmd_ready=(state==IDLE).
//  NOP/CLRERR: no busy cycle; ready stays high. CLRERR clears both error flags at the accept edge.
//  Underflow: POP needs depth>=1; DUP, ADD, SUB and SWAP need depth>=2 (DUP also needs depth>=1).
//   On violation: set err_underflow, issue no stack op, ready stays high, depth unchanged.
//  Overflow: PUSH or DUP with depth==STACK_SIZE sets err_overflow, no stack op.
//   ADD, SUB and SWAP never overflow (net depth <= 0).
//  Error flags persist until CLRERR or reset. Commands keep executing while a flag is set.
//  cmd/cmd_data are sampled only at accept. Changes while ready is low are ignored.
// STRUCTURE
//  Shared header stack_defs.vh holds:
//   - `define STACK_SIZE
//   - stack mode codes: HOLD=3'b000, PUSH=3'b001, POP=3'b010
//   - opcode constants
//  The stack_register instance uses the same header.
//  No sub-module: one FSM with an operand latch (a, b, result, carry) and a depth counter.
// TESTING
//  1. reset; PUSH 3, PUSH 5, ADD -> top=8, depth=1, carry=0; ready low exactly 3 cycles after ADD.
//  2. PUSH 2, PUSH 7, SUB -> top=4'hB (2-7 mod 16), carry=1; PUSH F, PUSH 1, ADD -> top=0, carry=1.
//  3. PUSH 1, PUSH 2, SWAP -> top=1, second=2, depth=2; stack_mode trace POP, POP, PUSH, PUSH.
//  4. empty stack: POP -> err_underflow=1, depth=0, stack_mode stays HOLD;
//     one PUSH then ADD -> underflow, depth=1; CLRERR -> flag=0.
//  5. 8 PUSHes -> depth=8; 9th PUSH and DUP -> err_overflow=1, depth=8, top unchanged;
//     POP -> depth=7.
//  6. reset asserted at N+2 of an ADD -> no PUSH issued, depth=0, ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/stack_sequencer_pkg.sv
// Shared definitions for the stack command sequencer: stack mode codes,
// calculator opcodes, FSM states and the arithmetic helper.
package stack_sequencer_pkg;

  localparam int unsigned STACK_SIZE_DEF = 8;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_PUSH = 3'b001,
    MODE_POP  = 3'b010
  } mode_e;

  typedef enum logic [2:0] {
    OP_NOP    = 3'b000,
    OP_PUSH   = 3'b001,
    OP_POP    = 3'b010,
    OP_DUP    = 3'b011,
    OP_ADD    = 3'b100,
    OP_SUB    = 3'b101,
    OP_SWAP   = 3'b110,
    OP_CLRERR = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_S1,
    ST_S2,
    ST_S3,
    ST_S4
  } state_e;

  // Bit 4 is the ADD carry or, for SUB, the borrow (a > b).
  function automatic logic [4:0] alu5(input opcode_e op, input logic [3:0] a,
                                      input logic [3:0] b);
    if (op == OP_SUB) return {1'b0, b} - {1'b0, a};
    else              return {1'b0, b} + {1'b0, a};
  endfunction

endpackage

// File: rtl/stack_sequencer.sv
// Command-side controller for the 4-bit LIFO: turns handshaked calculator
// commands into registered push/pop sequences, tracks depth and error flags.
module stack_sequencer
  import stack_sequencer_pkg::*;
#(
  parameter int unsigned STACK_SIZE = STACK_SIZE_DEF,
  localparam int unsigned DW = $clog2(STACK_SIZE + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  input  logic [2:0]    cmd,
  input  logic [3:0]    cmd_data,
  output logic          cmd_ready,
  output logic [2:0]    stack_mode,
  output logic [3:0]    stack_in,
  input  logic [3:0]    top_word,
  input  logic [3:0]    second_word,
  output logic [DW-1:0] depth,
  output logic          carry,
  output logic          err_overflow,
  output logic          err_underflow
);

  localparam logic [DW-1:0] FULL = DW'(STACK_SIZE);

  state_e        r_state;
  opcode_e       r_op;
  mode_e         r_mode;
  logic [3:0]    r_in;
  logic [3:0]    r_a;
  logic [3:0]    r_b;
  logic [3:0]    r_res;
  logic          r_cy_pend;
  logic [DW-1:0] r_depth;
  logic          r_carry;
  logic          r_ovf;
  logic          r_udf;

  state_e        w_state_nx;
  mode_e         w_mode_nx;
  logic [3:0]    w_in_nx;
  opcode_e       w_cmd;
  logic          w_start;
  logic          w_ovf_set;
  logic          w_udf_set;
  logic          w_clr;

  assign w_cmd = opcode_e'(cmd);

  always_comb begin
    w_state_nx = r_state;
    w_mode_nx  = MODE_HOLD;
    w_in_nx    = r_in;
    w_start    = 1'b0;
    w_ovf_set  = 1'b0;
    w_udf_set  = 1'b0;
    w_clr      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (w_cmd)
            OP_PUSH: begin
              if (r_depth == FULL) w_ovf_set = 1'b1;
              else begin
                w_start = 1'b1; w_mode_nx = MODE_PUSH; w_in_nx = cmd_data;
              end
            end
            OP_POP: begin
              if (r_depth == '0) w_udf_set = 1'b1;
              else begin
                w_start = 1'b1; w_mode_nx = MODE_POP;
              end
            end
            OP_DUP: begin
              if (r_depth < DW'(2)) w_udf_set = 1'b1;
              else if (r_depth == FULL) w_ovf_set = 1'b1;
              else begin
                w_start = 1'b1; w_mode_nx = MODE_PUSH; w_in_nx = top_word;
              end
            end
            OP_ADD, OP_SUB, OP_SWAP: begin
              if (r_depth < DW'(2)) w_udf_set = 1'b1;
              else begin
                w_start = 1'b1; w_mode_nx = MODE_POP;
              end
            end
            OP_CLRERR: w_clr = 1'b1;
            default: ;
          endcase
          if (w_start) w_state_nx = ST_S1;
        end
      end
      ST_S1: begin
        if (r_op == OP_ADD || r_op == OP_SUB || r_op == OP_SWAP) begin
          w_state_nx = ST_S2; w_mode_nx = MODE_POP;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_S2: begin
        w_state_nx = ST_S3;
        w_mode_nx  = MODE_PUSH;
        w_in_nx    = (r_op == OP_SWAP) ? r_a : r_res;
      end
      ST_S3: begin
        if (r_op == OP_SWAP) begin
          w_state_nx = ST_S4; w_mode_nx = MODE_PUSH; w_in_nx = r_b;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_NOP;
      r_mode    <= MODE_HOLD;
      r_in      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_cy_pend <= 1'b0;
      r_depth   <= '0;
      r_carry   <= 1'b0;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_mode  <= w_mode_nx;
      r_in    <= w_in_nx;
      // Depth follows the mode driven this cycle, i.e. the shift the stack applies now.
      case (r_mode)
        MODE_PUSH: r_depth <= r_depth + DW'(1);
        MODE_POP:  r_depth <= r_depth - DW'(1);
        default: ;
      endcase
      if (w_start) begin
        r_op <= w_cmd;
        r_a  <= top_word;
        r_b  <= second_word;
        {r_cy_pend, r_res} <= alu5(w_cmd, top_word, second_word);
      end
      if (r_state == ST_S3 && r_op != OP_SWAP) r_carry <= r_cy_pend;
      if (w_clr) begin
        r_ovf <= 1'b0;
        r_udf <= 1'b0;
      end else begin
        if (w_ovf_set) r_ovf <= 1'b1;
        if (w_udf_set) r_udf <= 1'b1;
      end
    end
  end

  assign cmd_ready     = (r_state == ST_IDLE);
  assign stack_mode    = r_mode;
  assign stack_in      = r_in;
  assign depth         = r_depth;
  assign carry         = r_carry;
  assign err_overflow  = r_ovf;
  assign err_underflow = r_udf;

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer with a behavioural 8-deep LIFO attached;
// expectations are queued per step and checked once the command completes.
module tb_stack_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd = 3'd0;
  logic [3:0] cmd_data = 4'd0;
  logic       cmd_ready;
  logic [2:0] stack_mode;
  logic [3:0] stack_in;
  logic [3:0] top_word;
  logic [3:0] second_word;
  logic [3:0] depth;
  logic       carry;
  logic       err_overflow;
  logic       err_underflow;

  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, DUP = 3'd3,
                         ADD = 3'd4, SUB = 3'd5, SWAP = 3'd6, CLRERR = 3'd7;
  localparam logic [2:0] M_HOLD = 3'd0, M_PUSH = 3'd1, M_POP = 3'd2;

  localparam int S_TOP = 0, S_SEC = 1, S_DEPTH = 2, S_CARRY = 3, S_OVF = 4,
                 S_UDF = 5, S_READY = 6, S_BUSY = 7, S_MODE = 8, S_TRACE = 10;

  stack_sequencer #(.STACK_SIZE(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd),
    .cmd_data(cmd_data), .cmd_ready(cmd_ready), .stack_mode(stack_mode),
    .stack_in(stack_in), .top_word(top_word), .second_word(second_word),
    .depth(depth), .carry(carry), .err_overflow(err_overflow),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  // Behavioural stack_register: contents survive reset.
  logic [3:0] stk [8] = '{default: 4'd0};
  always @(posedge clk) begin
    if (stack_mode == M_PUSH) begin
      for (int i = 7; i > 0; i--) stk[i] <= stk[i-1];
      stk[0] <= stack_in;
    end else if (stack_mode == M_POP) begin
      for (int i = 0; i < 7; i++) stk[i] <= stk[i+1];
      stk[7] <= 4'd0;
    end
  end
  assign top_word    = stk[0];
  assign second_word = stk[1];

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] exp;
  } exp_t;

  exp_t       sbq[$];
  int         ncmp = 0;
  int         nfail = 0;
  int         last_busy = 0;
  logic [2:0] trace [16];

  function automatic logic [7:0] obs(input int sel);
    case (sel)
      S_TOP:   return {4'd0, top_word};
      S_SEC:   return {4'd0, second_word};
      S_DEPTH: return {4'd0, depth};
      S_CARRY: return {7'd0, carry};
      S_OVF:   return {7'd0, err_overflow};
      S_UDF:   return {7'd0, err_underflow};
      S_READY: return {7'd0, cmd_ready};
      S_BUSY:  return last_busy[7:0];
      S_MODE:  return {5'd0, stack_mode};
      default: return {5'd0, trace[(sel - S_TRACE) & 15]};
    endcase
  endfunction

  task automatic expect_v(input string tag, input int sel, input logic [7:0] v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = v;
    sbq.push_back(e);
  endtask

  task automatic check_all();
    exp_t e;
    logic [7:0] o;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      o = obs(e.sel);
      ncmp++;
      assert (o === e.exp) else begin
        nfail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Issue one command, then scramble cmd/cmd_data (must be ignored) and
  // count the cycles ready stays low, recording stack_mode each cycle.
  task automatic do_cmd(input logic [2:0] op, input logic [3:0] d);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd = op; cmd_data = d;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd = 3'($urandom_range(0, 7));
    cmd_data = 4'($urandom_range(0, 15));
    last_busy = 0;
    n = 0;
    for (int i = 0; i < 16; i++) trace[i] = 3'd7;
    forever begin
      @(negedge clk);
      trace[n] = stack_mode;
      n++;
      if (cmd_ready) break;
      last_busy++;
      if (n >= 15) begin
        ncmp++;
        nfail++;
        $error("FAIL ready_timeout: observed busy %0d expected ready", last_busy);
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    do_reset();
    expect_v("rst_ready", S_READY, 8'd1);
    expect_v("rst_mode", S_MODE, 8'(M_HOLD));
    expect_v("rst_depth", S_DEPTH, 8'd0);
    expect_v("rst_carry", S_CARRY, 8'd0);
    expect_v("rst_ovf", S_OVF, 8'd0);
    expect_v("rst_udf", S_UDF, 8'd0);
    check_all();
    ncmp++;
    assert (stack_in === 4'd0) else begin
      nfail++;
      $error("FAIL rst_in: observed %0h expected 0", stack_in);
    end

    // 1: 3 + 5
    do_cmd(PUSH, 4'd3);
    expect_v("push_busy", S_BUSY, 8'd1);
    expect_v("push_trace0", S_TRACE, 8'(M_PUSH));
    check_all();
    do_cmd(PUSH, 4'd5);
    expect_v("add_top", S_TOP, 8'd8);
    expect_v("add_depth", S_DEPTH, 8'd1);
    expect_v("add_carry", S_CARRY, 8'd0);
    expect_v("add_busy", S_BUSY, 8'd3);
    expect_v("add_tr0", S_TRACE + 0, 8'(M_POP));
    expect_v("add_tr1", S_TRACE + 1, 8'(M_POP));
    expect_v("add_tr2", S_TRACE + 2, 8'(M_PUSH));
    do_cmd(ADD, 4'd0);
    check_all();

    // 2: 2 - 7 borrows; F + 1 carries
    do_cmd(PUSH, 4'd2);
    do_cmd(PUSH, 4'd7);
    expect_v("sub_top", S_TOP, 8'h0B);
    expect_v("sub_sec", S_SEC, 8'h08);
    expect_v("sub_carry", S_CARRY, 8'd1);
    expect_v("sub_depth", S_DEPTH, 8'd2);
    do_cmd(SUB, 4'd0);
    check_all();
    do_cmd(PUSH, 4'hF);
    do_cmd(PUSH, 4'h1);
    expect_v("addc_top", S_TOP, 8'd0);
    expect_v("addc_carry", S_CARRY, 8'd1);
    expect_v("addc_depth", S_DEPTH, 8'd3);
    do_cmd(ADD, 4'd0);
    check_all();

    // 3: SWAP
    do_reset();
    do_cmd(PUSH, 4'd1);
    do_cmd(PUSH, 4'd2);
    expect_v("swap_top", S_TOP, 8'd1);
    expect_v("swap_sec", S_SEC, 8'd2);
    expect_v("swap_depth", S_DEPTH, 8'd2);
    expect_v("swap_busy", S_BUSY, 8'd4);
    expect_v("swap_tr0", S_TRACE + 0, 8'(M_POP));
    expect_v("swap_tr1", S_TRACE + 1, 8'(M_POP));
    expect_v("swap_tr2", S_TRACE + 2, 8'(M_PUSH));
    expect_v("swap_tr3", S_TRACE + 3, 8'(M_PUSH));
    expect_v("swap_tr4", S_TRACE + 4, 8'(M_HOLD));
    do_cmd(SWAP, 4'd0);
    check_all();
    expect_v("nop_busy", S_BUSY, 8'd0);
    expect_v("nop_depth", S_DEPTH, 8'd2);
    do_cmd(NOP, 4'd9);
    check_all();

    // 4: underflow
    do_reset();
    expect_v("udf_pop_flag", S_UDF, 8'd1);
    expect_v("udf_pop_depth", S_DEPTH, 8'd0);
    expect_v("udf_pop_busy", S_BUSY, 8'd0);
    expect_v("udf_pop_mode", S_TRACE, 8'(M_HOLD));
    do_cmd(POP, 4'd0);
    check_all();
    expect_v("clr1_udf", S_UDF, 8'd0);
    do_cmd(CLRERR, 4'd0);
    check_all();
    do_cmd(PUSH, 4'd4);
    expect_v("udf_add_flag", S_UDF, 8'd1);
    expect_v("udf_add_depth", S_DEPTH, 8'd1);
    expect_v("udf_add_busy", S_BUSY, 8'd0);
    expect_v("udf_add_top", S_TOP, 8'd4);
    do_cmd(ADD, 4'd0);
    check_all();
    expect_v("clr2_udf", S_UDF, 8'd0);
    expect_v("clr2_busy", S_BUSY, 8'd0);
    do_cmd(CLRERR, 4'd0);
    check_all();

    // 5: overflow
    do_reset();
    for (int i = 0; i < 8; i++) do_cmd(PUSH, 4'(i));
    expect_v("full_depth", S_DEPTH, 8'd8);
    expect_v("full_top", S_TOP, 8'd7);
    expect_v("full_sec", S_SEC, 8'd6);
    check_all();
    expect_v("ovf_push_flag", S_OVF, 8'd1);
    expect_v("ovf_push_depth", S_DEPTH, 8'd8);
    expect_v("ovf_push_top", S_TOP, 8'd7);
    expect_v("ovf_push_busy", S_BUSY, 8'd0);
    do_cmd(PUSH, 4'd9);
    check_all();
    expect_v("clr3_ovf", S_OVF, 8'd0);
    do_cmd(CLRERR, 4'd0);
    check_all();
    expect_v("ovf_dup_flag", S_OVF, 8'd1);
    expect_v("ovf_dup_depth", S_DEPTH, 8'd8);
    expect_v("ovf_dup_top", S_TOP, 8'd7);
    do_cmd(DUP, 4'd0);
    check_all();
    expect_v("pop_depth", S_DEPTH, 8'd7);
    expect_v("pop_top", S_TOP, 8'd6);
    expect_v("pop_busy", S_BUSY, 8'd1);
    expect_v("pop_ovf_sticky", S_OVF, 8'd1);
    do_cmd(POP, 4'd0);
    check_all();
    expect_v("dup_top", S_TOP, 8'd6);
    expect_v("dup_sec", S_SEC, 8'd6);
    expect_v("dup_depth", S_DEPTH, 8'd8);
    do_cmd(DUP, 4'd0);
    check_all();
    do_cmd(POP, 4'd0);

    // 6: reset during cycle N+2 of an ADD
    @(negedge clk);
    cmd_valid = 1'b1; cmd = ADD;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    expect_v("abort_mode0", S_MODE, 8'(M_HOLD));
    expect_v("abort_depth0", S_DEPTH, 8'd0);
    check_all();
    @(negedge clk);
    expect_v("abort_ready", S_READY, 8'd1);
    expect_v("abort_depth", S_DEPTH, 8'd0);
    expect_v("abort_mode1", S_MODE, 8'(M_HOLD));
    expect_v("abort_carry", S_CARRY, 8'd0);
    expect_v("abort_ovf", S_OVF, 8'd0);
    check_all();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      expect_v("abort_hold", S_MODE, 8'(M_HOLD));
      check_all();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
